// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned REG_X0    = 0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Per-source writeback FIFO; exposes entries in oldest-to-youngest order.
// RF_WB_FWD_EN adds the entry data view used by forwarding lookup.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  wb_entry_t            din,
  input  logic                 pop,
  output wb_entry_t            dout,
  output logic                 full,
  output logic                 empty,
  output logic                 ent_valid [DEPTH],
  output logic [RF_ADDR_W-1:0] ent_rd    [DEPTH]
`ifdef RF_WB_FWD_EN
  ,
  output logic [RF_DATA_W-1:0] ent_data  [DEPTH]
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Pointers and occupancy; caller never pushes when full or pops when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Index 0 is the head; entries at index >= count are stale.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = (CNT_W'(i) < count);
      ent_rd[i]    = mem[rd_ptr + PTR_W'(i)].rd;
`ifdef RF_WB_FWD_EN
      ent_data[i]  = mem[rd_ptr + PTR_W'(i)].data;
`endif
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two sources.
// RF_WB_FWD_EN adds two combinational forwarding lookup ports.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s0_valid,
  output logic                 s0_ready,
  input  logic [ADDR_W-1:0]    s0_rd,
  input  logic [DATA_W-1:0]    s0_data,
  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic [ADDR_W-1:0]    s1_rd,
  input  logic [DATA_W-1:0]    s1_data,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    write,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] busy
`ifdef RF_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]    fwd_addr_1,
  input  logic [ADDR_W-1:0]    fwd_addr_2,
  output logic                 fwd_hit_1,
  output logic                 fwd_hit_2,
  output logic [DATA_W-1:0]    fwd_data_1,
  output logic [DATA_W-1:0]    fwd_data_2
`endif
);

  wb_entry_t            in0, in1, head0, head1;
  logic                 full0, empty0, full1, empty1;
  logic                 push0, push1, grant0, grant1;
  logic                 last_grant;
  logic                 ent_v0  [DEPTH];
  logic                 ent_v1  [DEPTH];
  logic [RF_ADDR_W-1:0] ent_rd0 [DEPTH];
  logic [RF_ADDR_W-1:0] ent_rd1 [DEPTH];
`ifdef RF_WB_FWD_EN
  logic [RF_DATA_W-1:0] ent_d0  [DEPTH];
  logic [RF_DATA_W-1:0] ent_d1  [DEPTH];
`endif

  // Writes to x0 complete the handshake but are dropped here.
  assign s0_ready = !full0;
  assign s1_ready = !full1;
  assign push0    = s0_valid && !full0 && (s0_rd != ADDR_W'(REG_X0));
  assign push1    = s1_valid && !full1 && (s1_rd != ADDR_W'(REG_X0));
  assign in0      = '{rd: RF_ADDR_W'(s0_rd), data: RF_DATA_W'(s0_data)};
  assign in1      = '{rd: RF_ADDR_W'(s1_rd), data: RF_DATA_W'(s1_data)};

  // last_grant=1 means src1 went last, so src0 wins the next tie.
  assign grant0 = !empty0 && (empty1 || last_grant);
  assign grant1 = !empty1 && (empty0 || !last_grant);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .din       (in0),
    .pop       (grant0),
    .dout      (head0),
    .full      (full0),
    .empty     (empty0),
    .ent_valid (ent_v0),
    .ent_rd    (ent_rd0)
`ifdef RF_WB_FWD_EN
    ,
    .ent_data  (ent_d0)
`endif
  );

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .din       (in1),
    .pop       (grant1),
    .dout      (head1),
    .full      (full1),
    .empty     (empty1),
    .ent_valid (ent_v1),
    .ent_rd    (ent_rd1)
`ifdef RF_WB_FWD_EN
    ,
    .ent_data  (ent_d1)
`endif
  );

  // Registered write stage; index and data hold while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite   <= 1'b0;
      write      <= '0;
      write_data <= '0;
      last_grant <= 1'b1;
    end else if (grant0) begin
      RegWrite   <= 1'b1;
      write      <= ADDR_W'(head0.rd);
      write_data <= DATA_W'(head0.data);
      last_grant <= 1'b0;
    end else if (grant1) begin
      RegWrite   <= 1'b1;
      write      <= ADDR_W'(head1.rd);
      write_data <= DATA_W'(head1.data);
      last_grant <= 1'b1;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_v0[i]) busy[ent_rd0[i]] = 1'b1;
      if (ent_v1[i]) busy[ent_rd1[i]] = 1'b1;
    end
    if (RegWrite) busy[write] = 1'b1;
    busy[REG_X0] = 1'b0;
  end

`ifdef RF_WB_FWD_EN
  logic [ADDR_W-1:0] lk_addr [2];
  logic              lk_hit  [2];
  logic [DATA_W-1:0] lk_data [2];

  assign lk_addr[0] = fwd_addr_1;
  assign lk_addr[1] = fwd_addr_2;
  assign fwd_hit_1  = lk_hit[0];
  assign fwd_hit_2  = lk_hit[1];
  assign fwd_data_1 = lk_data[0];
  assign fwd_data_2 = lk_data[1];

  // Scan oldest to youngest so the last match is the youngest value.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_hit[p]  = 1'b0;
      lk_data[p] = '0;
      if (RegWrite && (write == lk_addr[p])) begin
        lk_hit[p]  = 1'b1;
        lk_data[p] = write_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_v0[i] && (ADDR_W'(ent_rd0[i]) == lk_addr[p])) begin
          lk_hit[p]  = 1'b1;
          lk_data[p] = DATA_W'(ent_d0[i]);
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_v1[i] && (ADDR_W'(ent_rd1[i]) == lk_addr[p])) begin
          lk_hit[p]  = 1'b1;
          lk_data[p] = DATA_W'(ent_d1[i]);
        end
      end
      if (lk_addr[p] == ADDR_W'(REG_X0)) begin
        lk_hit[p]  = 1'b0;
        lk_data[p] = '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a queue-based reference model.
// Covers the RF_WB_FWD_EN lookup ports when that macro is defined.
module tb_rf_write_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [4:0]  s0_rd, s1_rd, write;
  logic [31:0] s0_data, s1_data, write_data;
  logic        RegWrite;
  logic [31:0] busy;
`ifdef RF_WB_FWD_EN
  logic [4:0]  fwd_addr_1, fwd_addr_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data_1, fwd_data_2;
`endif

  rf_write_arbiter #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .s0_valid   (s0_valid),
    .s0_ready   (s0_ready),
    .s0_rd      (s0_rd),
    .s0_data    (s0_data),
    .s1_valid   (s1_valid),
    .s1_ready   (s1_ready),
    .s1_rd      (s1_rd),
    .s1_data    (s1_data),
    .RegWrite   (RegWrite),
    .write      (write),
    .write_data (write_data),
    .busy       (busy)
`ifdef RF_WB_FWD_EN
    ,
    .fwd_addr_1 (fwd_addr_1),
    .fwd_addr_2 (fwd_addr_2),
    .fwd_hit_1  (fwd_hit_1),
    .fwd_hit_2  (fwd_hit_2),
    .fwd_data_1 (fwd_data_1),
    .fwd_data_2 (fwd_data_2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model: two queues, one output register, last-granted source.
  ent_t        q0[$], q1[$];
  logic        out_v;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  int          lg;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          wlog[$], wcyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    out_v = 1'b0; out_rd = '0; out_data = '0; lg = 1;
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    foreach (q0[i]) b[q0[i].rd] = 1'b1;
    foreach (q1[i]) b[q1[i].rd] = 1'b1;
    if (out_v) b[out_rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

`ifdef RF_WB_FWD_EN
  task automatic m_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0; d = '0;
    if (out_v && out_rd == a) begin hit = 1'b1; d = out_data; end
    foreach (q0[i]) if (q0[i].rd == a) begin hit = 1'b1; d = q0[i].data; end
    foreach (q1[i]) if (q1[i].rd == a) begin hit = 1'b1; d = q1[i].data; end
    if (a == 0) hit = 1'b0;
  endtask
`endif

  task automatic check_comb();
`ifdef RF_WB_FWD_EN
    logic        h;
    logic [31:0] d;
`endif
    check("s0_ready", s0_ready, q0.size() < DEPTH);
    check("s1_ready", s1_ready, q1.size() < DEPTH);
`ifdef RF_WB_FWD_EN
    m_fwd(fwd_addr_1, h, d);
    check("fwd_hit_1", fwd_hit_1, h);
    if (h) check("fwd_data_1", fwd_data_1, d);
    m_fwd(fwd_addr_2, h, d);
    check("fwd_hit_2", fwd_hit_2, h);
    if (h) check("fwd_data_2", fwd_data_2, d);
`endif
  endtask

  task automatic check_outputs();
    check("regwrite", RegWrite, out_v);
    check("write", write, out_rd);
    check("write_data", write_data, out_data);
    check("busy", busy, m_busy());
  endtask

  // One clock: drive at negedge, model the edge, compare at the next negedge.
  task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                      output logic a0, output logic a1);
    ent_t e;
    int   g;
    s0_valid = v0; s0_rd = r0; s0_data = d0;
    s1_valid = v1; s1_rd = r1; s1_data = d1;
    #1;
    check_comb();
    a0 = v0 && (q0.size() < DEPTH);
    a1 = v1 && (q1.size() < DEPTH);
    g = -1;
    if (q0.size() > 0 && (q1.size() == 0 || lg == 1)) g = 0;
    else if (q1.size() > 0) g = 1;
    if (g == 0) begin
      e = q0.pop_front(); out_v = 1'b1; out_rd = e.rd; out_data = e.data; lg = 0;
    end else if (g == 1) begin
      e = q1.pop_front(); out_v = 1'b1; out_rd = e.rd; out_data = e.data; lg = 1;
    end else begin
      out_v = 1'b0;
    end
    if (a0 && r0 != 0) q0.push_back('{rd: r0, data: d0});
    if (a1 && r1 != 0) q1.push_back('{rd: r1, data: d1});
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (RegWrite) begin wlog.push_back(int'(write)); wcyc.push_back(cyc); end
    cyc++;
  endtask

  task automatic idle(input int n);
    logic a0, a1;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s0_valid = 0; s1_valid = 0; s0_rd = 0; s1_rd = 0; s0_data = 0; s1_data = 0;
    #1;
    model_reset();
    check("rst_regwrite", RegWrite, 0);
    check("rst_write", write, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_s0_ready", s0_ready, 1);
    check("rst_s1_ready", s1_ready, 1);
  endtask

  initial begin : main
    logic        a0, a1, p0v, p1v, seen_full;
    logic [4:0]  p0r, p1r;
    logic [31:0] p0d, p1d;
    int          i0, i1, guard;
    int          exp_ord[8] = '{1, 11, 2, 12, 3, 13, 4, 14};

    rst = 1'b0;
    s0_valid = 0; s1_valid = 0; s0_rd = 0; s1_rd = 0; s0_data = 0; s1_data = 0;
`ifdef RF_WB_FWD_EN
    fwd_addr_1 = 5; fwd_addr_2 = 0;
`endif
    @(negedge clk);
    do_reset();

    // Single write: two edges from accept to RegWrite.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, a0, a1);
    check("lat_busy5_after_accept", busy[5], 1);
    check("lat_no_early_write", RegWrite, 0);
    step(0, 0, 0, 0, 0, 0, a0, a1);
    check("lat_regwrite", RegWrite, 1);
    check("lat_write", write, 5);
    check("lat_write_data", write_data, 32'hDEADBEEF);
    check("lat_busy5_in_stage", busy[5], 1);
    step(0, 0, 0, 0, 0, 0, a0, a1);
    check("lat_busy5_clear", busy[5], 0);

    // Dual stream from a fresh reset: alternating, no bubbles.
    @(negedge clk);
    do_reset();
    wlog.delete(); wcyc.delete();
    i0 = 0; i1 = 0; guard = 0;
    while ((i0 < 4 || i1 < 4) && guard < 50) begin
      step(i0 < 4, 5'(i0 + 1), $urandom, i1 < 4, 5'(i1 + 11), $urandom, a0, a1);
      if (a0) i0++;
      if (a1) i1++;
      guard++;
    end
    check("stream_accept_bound", guard < 50, 1);
    idle(4);
    check("stream_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      for (int k = 0; k < 8; k++) check("stream_order", wlog[k], exp_ord[k]);
      check("stream_contiguous", wcyc[7] - wcyc[0], 7);
    end

    // src0 saturating while src1 holds its request until accepted.
    seen_full = 1'b0; p1v = 1'b0; p1r = 0; p1d = 0;
    for (int c = 0; c < 24; c++) begin
      if (!p1v) begin p1v = 1'b1; p1r = 5'(8 + $urandom_range(7)); p1d = $urandom; end
      step(1, 5'(1 + $urandom_range(6)), $urandom, p1v, p1r, p1d, a0, a1);
      if (a1) p1v = 1'b0;
      if (!s1_ready) seen_full = 1'b1;
    end
    check("s1_full_seen", seen_full, 1);
    idle(4);

    // Write to x0 is accepted and dropped.
    step(1, 0, 32'h1234, 0, 0, 0, a0, a1);
    check("x0_ready", s0_ready, 1);
    for (int k = 0; k < 3; k++) begin
      check("x0_no_regwrite", RegWrite, 0);
      check("x0_busy", busy, 0);
      step(0, 0, 0, 0, 0, 0, a0, a1);
    end

    // Random traffic with held requests and random lookups.
    p0v = 1'b0; p1v = 1'b0; p0r = 0; p0d = 0;
    for (int c = 0; c < 300; c++) begin
      if (!p0v && $urandom_range(3) != 0) begin
        p0v = 1'b1; p0r = 5'($urandom_range(7)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(3) != 0) begin
        p1v = 1'b1;
        p1r = ($urandom_range(7) == 0) ? 5'd0 : 5'(8 + $urandom_range(7));
        p1d = $urandom;
      end
`ifdef RF_WB_FWD_EN
      fwd_addr_1 = 5'($urandom_range(15));
      fwd_addr_2 = 5'($urandom_range(15));
`endif
      step(p0v, p0r, p0d, p1v, p1r, p1d, a0, a1);
      if (a0) p0v = 1'b0;
      if (a1) p1v = 1'b0;
    end
    idle(4);

    // Reset mid-stream with three entries buffered.
    step(1, 1, 32'h11, 1, 2, 32'h22, a0, a1);
    step(1, 3, 32'h33, 1, 4, 32'h44, a0, a1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_regwrite", RegWrite, 0);
    check("midrst_busy", busy, 0);
    model_reset();
    s0_valid = 0; s1_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_s0_ready", s0_ready, 1);
    check("midrst_s1_ready", s1_ready, 1);
    wlog.delete();
    idle(5);
    check("midrst_no_stale", wlog.size(), 0);

`ifdef RF_WB_FWD_EN
    // Forwarding returns the youngest pending value for rd 7.
    fwd_addr_1 = 7; fwd_addr_2 = 0;
    step(1, 7, 32'hA, 0, 0, 0, a0, a1);
    step(1, 7, 32'hB, 0, 0, 0, a0, a1);
    check("fwd_youngest_hit", fwd_hit_1, 1);
    check("fwd_youngest_data", fwd_data_1, 32'hB);
    check("fwd_x0_never_hits", fwd_hit_2, 0);
    idle(2);
    check("fwd_drained", fwd_hit_1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (RegWrite/write/write_data) between two writeback requesters: src0 = ALU/execute result, src1 = load/memory result.
- Each source has a valid/ready handshake into its own small FIFO. Round-robin arbitration pops one entry per cycle into a registered write stage that drives the register file.
- Exports a pending-write busy mask so decode can stall on registers with in-flight writes.

Parameters:
- DEPTH, 2, entries per source FIFO (power of 2, >=2)
- ADDR_W, 5, register index width
- DATA_W, 32, write data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s0_valid  in  1  src0 write request
- s0_ready  out  1  src0 FIFO can accept
- s0_rd  in  ADDR_W  src0 destination register
- s0_data  in  DATA_W  src0 write data
- s1_valid, s1_ready, s1_rd, s1_data  same as src0, for src1
- RegWrite  out  1  write enable to register file
- write  out  ADDR_W  write register index
- write_data  out  DATA_W  write data
- busy  out  2^ADDR_W  bit r = 1 while a write to r is buffered or in the output stage

Behaviour:
- Reset (rst=0, async):
  - FIFOs empty; RegWrite=0, write=0, write_data=0.
  - last_grant=1, so src0 wins the first tie.
  - busy=0; s0_ready=s1_ready=1 once rst deasserts.
- Accept: transfer on sX_valid & sX_ready at a rising edge. sX_ready = !fullX. Ready is not lowered by a same-cycle pop; no pass-through path.
- x0: a transfer with sX_rd==0 is accepted (ready rules unchanged) but not stored. It never produces RegWrite and never sets busy.
- Arbitration, each cycle, combinational on FIFO heads:
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the source != last_grant. last_grant updates to the granted source.
  - Neither non-empty: no grant, last_grant holds.
- Output stage, registered:
  - On a grant, pop the head. Next edge: RegWrite=1, write=head.rd, write_data=head.data.
  - No grant: RegWrite=0; write/write_data hold their previous values.
- Latency: accept at edge N, if granted immediately, gives RegWrite=1 in the cycle after edge N+1. Minimum 2 edges from accept to output.
- Throughput: 1 write/cycle aggregate. Each source gets >=1 grant every 2 cycles under contention.
- Ordering:
  - FIFO order within a source.
  - No ordering between sources. Decode must stall on busy[rd] so two sources never target the same rd concurrently. This is not checked in RTL.
- Busy mask:
  - busy[r] = OR over valid entries of both FIFOs (rd==r), OR (RegWrite & write==r).
  - busy[0]=0 always.
  - Combinational from state, so it updates the cycle after accept or pop.
- Full: sX_ready=0. sX_valid held high is legal and must not corrupt state; data is accepted once ready rises.
- Simultaneous push and pop on the same FIFO, non-full: both occur and the count is unchanged.
- Pointers wrap modulo DEPTH; count has width clog2(DEPTH)+1.
- Reset asserted mid-operation: all buffered writes are discarded and RegWrite drops immediately (async).

Optional Feature:
- Macro RF_WB_FWD_EN.
- When defined, adds forwarding lookup ports:
  - fwd_addr_1, fwd_addr_2 (in, ADDR_W)
  - fwd_hit_1, fwd_hit_2 (out, 1)
  - fwd_data_1, fwd_data_2 (out, DATA_W)
- Lookup rules:
  - A hit returns the youngest matching pending value. Search order: output stage (oldest), then FIFO entries oldest to youngest within each source, with the last match winning.
  - Sources never collide per the ordering rule.
  - Address 0 never hits.
  - Purely combinational.
- Without the macro: the ports are absent and there is no lookup logic.

Decomposition:
- Shared package rf_pkg:
  - ADDR_W/DATA_W defaults
  - typedef wb_entry_t {rd, data}
  - constant REG_X0=0
- One sub-module, rf_wb_fifo: parametrised DEPTH, storing wb_entry_t. Provides push/pop/full/empty and exposes entry valid/rd/data arrays for the busy mask and forwarding. Instantiated twice.

Test Plan:
- Reset, then src0 writes rd=5, data=0xDEADBEEF. Required: RegWrite=1, write=5, write_data=0xDEADBEEF exactly 2 edges after accept. busy[5]=1 from the cycle after accept until the cycle after RegWrite.
- Both sources stream 4 writes each from the same cycle (rd 1-4 and 11-14). Required: output order 1,11,2,12,3,13,4,14; no bubbles; RegWrite high for 8 consecutive cycles.
- Hold s1_valid with no pops possible beyond FIFO (DEPTH=2, src0 saturating). Required: s1_ready=0 when full. Data is held and accepted later; no entry is lost or duplicated (scoreboard compare).
- src0 writes rd=0, data=0x1234. Required: s0_ready unaffected, RegWrite never asserts, busy stays 0.
- Assert rst low mid-stream with 3 entries buffered. Required: RegWrite=0 and busy=0 immediately; after release both ready=1 and no stale writes appear.
- With RF_WB_FWD_EN, buffer src0 rd=7 values 0xA then 0xB. Required: fwd_hit_1=1 and fwd_data_1=0xB. Once both entries drain, fwd_hit_1=0.
